onchip_ram_pipelined: RTL and testbench

//  Parametrised single-port Avalon-MM on-chip RAM slave for the Nios II subsystem; successor to the fixed 32x6250 RAM.

---
 rtl/onchip_ram_pkg.sv | 20 ++
 rtl/onchip_ram_if.sv | 27 ++
 rtl/onchip_ram_core.sv | 49 ++++
 rtl/onchip_ram_pipelined.sv | 211 +++++++++++++++++++++
 tb/tb_onchip_ram_pipelined.sv | 275 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/onchip_ram_pkg.sv
// onchip_ram_pkg: shared types and constants for the pipelined on-chip RAM slave.
//   state_t       controller state (sweep-clear or ready for traffic)
//   READ_LAT_MIN  shortest supported read latency (unregistered RAM output)
//   READ_LAT_MAX  longest supported read latency (extra output register)
//   lane_count()  number of byte lanes in a data word
package onchip_ram_pkg;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } state_t;

    localparam int READ_LAT_MIN = 1;
    localparam int READ_LAT_MAX = 2;

    function automatic int lane_count(input int data_w);
        return data_w / 8;
    endfunction

endpackage

// File: rtl/onchip_ram_if.sv
// onchip_ram_if: Avalon-MM slave bus bundle for the on-chip RAM.
//   master modport drives address/byteenable/chipselect/read/write/writedata and
//   receives waitrequest/readdata/readdatavalid; slave modport is the mirror image.
interface onchip_ram_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 13
);
    logic [ADDR_W-1:0]   address;
    logic [DATA_W/8-1:0] byteenable;
    logic                chipselect;
    logic                read;
    logic                write;
    logic [DATA_W-1:0]   writedata;
    logic                waitrequest;
    logic [DATA_W-1:0]   readdata;
    logic                readdatavalid;

    modport master (
        output address, byteenable, chipselect, read, write, writedata,
        input  waitrequest, readdata, readdatavalid
    );

    modport slave (
        input  address, byteenable, chipselect, read, write, writedata,
        output waitrequest, readdata, readdatavalid
    );
endinterface

// File: rtl/onchip_ram_core.sv
// onchip_ram_core: inferred single-port RAM with per-lane write enables.
//   clk    clock
//   en     clock enable; low freezes writes, the read register and the output register
//   addr   word index
//   we     one write enable per lane
//   wdata  write word (LANES lanes of LANE_W bits)
//   re     load the read register from addr
//   q      read word; one register after the read when OUT_REG=0, two when OUT_REG=1
module onchip_ram_core #(
    parameter int LANES   = 4,
    parameter int LANE_W  = 8,
    parameter int DEPTH   = 16,
    parameter int IDX_W   = 4,
    parameter int OUT_REG = 0
) (
    input  logic                      clk,
    input  logic                      en,
    input  logic [IDX_W-1:0]          addr,
    input  logic [LANES-1:0]          we,
    input  logic [LANES*LANE_W-1:0]   wdata,
    input  logic                      re,
    output logic [LANES*LANE_W-1:0]   q
);
    logic [LANES*LANE_W-1:0] mem [DEPTH];
    logic [LANES*LANE_W-1:0] q_p0;

    // Stage p0: synchronous read-first access
    always_ff @(posedge clk) begin
        if (en) begin
            for (int i = 0; i < LANES; i++) begin
                if (we[i]) mem[addr][i*LANE_W +: LANE_W] <= wdata[i*LANE_W +: LANE_W];
            end
            if (re) q_p0 <= mem[addr];
        end
    end

    // Stage p1: optional output register
    generate
        if (OUT_REG != 0) begin : g_oreg
            logic [LANES*LANE_W-1:0] q_p1;
            always_ff @(posedge clk) begin
                if (en) q_p1 <= q_p0;
            end
            assign q = q_p1;
        end else begin : g_noreg
            assign q = q_p0;
        end
    endgenerate
endmodule

// File: rtl/onchip_ram_pipelined.sv
// onchip_ram_pipelined: parametrised Avalon-MM on-chip RAM slave with 1/2-cycle pipelined
// reads, post-reset clear sweep and out-of-range protection.
//   clk, reset_n      clock, asynchronous active-low reset
//   bus (slave)       Avalon-MM address/byteenable/chipselect/read/write/writedata,
//                     waitrequest/readdata/readdatavalid
//   clken, reset_req  either one (clken low / reset_req high) freezes the whole block
//   oor_err           sticky flag: an accepted access addressed a word >= DEPTH
//   parity_err        (ONCHIP_RAM_PARITY_EN only) pulses with readdatavalid on a bad byte
//   parity_err_addr   (ONCHIP_RAM_PARITY_EN only) first failing read address, held until reset
// Optional feature macro: ONCHIP_RAM_PARITY_EN adds one even-parity bit per stored byte.
module onchip_ram_pipelined
    import onchip_ram_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 13,
    parameter int DEPTH    = 6250,
    parameter int READ_LAT = 1,
    parameter int CLEAR_EN = 1
) (
    input  logic              clk,
    input  logic              reset_n,
    onchip_ram_if.slave       bus,
    input  logic              clken,
    input  logic              reset_req,
    output logic              oor_err
`ifdef ONCHIP_RAM_PARITY_EN
    ,
    output logic              parity_err,
    output logic [ADDR_W-1:0] parity_err_addr
`endif
);
    localparam int LANES = lane_count(DATA_W);
`ifdef ONCHIP_RAM_PARITY_EN
    localparam int LANE_W = 9;
`else
    localparam int LANE_W = 8;
`endif
    localparam int WORD_W = LANES * LANE_W;
    localparam int IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    function automatic logic [WORD_W-1:0] pack_word(input logic [DATA_W-1:0] d);
        logic [WORD_W-1:0] w;
        w = '0;
        for (int i = 0; i < LANES; i++) begin
            w[i*LANE_W +: 8] = d[i*8 +: 8];
`ifdef ONCHIP_RAM_PARITY_EN
            w[i*LANE_W + 8] = ^d[i*8 +: 8];
`endif
        end
        return w;
    endfunction

    function automatic logic [DATA_W-1:0] unpack_word(input logic [WORD_W-1:0] w);
        logic [DATA_W-1:0] d;
        d = '0;
        for (int i = 0; i < LANES; i++) d[i*8 +: 8] = w[i*LANE_W +: 8];
        return d;
    endfunction

    state_t              state, state_nxt;
    logic                started;
    logic [ADDR_W-1:0]   clear_ptr;
    logic                stall, clearing, in_rng, acc, wr_acc, rd_acc;
    logic [IDX_W-1:0]    ram_addr;
    logic [LANES-1:0]    ram_we;
    logic [WORD_W-1:0]   ram_wdata, ram_q;
    logic                vld_p0, oor_p0, vld_out, oor_out;
`ifdef ONCHIP_RAM_PARITY_EN
    logic [LANES-1:0]    be_p0, be_out, lane_bad;
    logic [ADDR_W-1:0]   addr_p0, addr_out;
    logic                par_seen;
`endif

    assign stall    = ~clken | reset_req;
    assign clearing = (state == ST_CLEAR);
    // started keeps waitrequest high during reset even when no clear sweep follows
    assign bus.waitrequest = ~started | clearing | stall;
    assign in_rng   = ({1'b0, bus.address} < (ADDR_W+1)'(DEPTH));
    assign acc      = bus.chipselect & (bus.read | bus.write) & ~bus.waitrequest;
    assign wr_acc   = acc & bus.write;
    // a simultaneous read+write is treated as a write only
    assign rd_acc   = acc & bus.read & ~bus.write;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= (CLEAR_EN != 0) ? ST_CLEAR : ST_READY;
            started   <= 1'b0;
            clear_ptr <= '0;
        end else begin
            started <= 1'b1;
            state   <= state_nxt;
            if (clearing && !stall) clear_ptr <= clear_ptr + 1'b1;
        end
    end

    always_comb begin
        state_nxt = state;
        if (clearing && !stall && clear_ptr == ADDR_W'(DEPTH - 1)) state_nxt = ST_READY;
    end

    // The sweep owns the single RAM port while clearing; zero data carries zero parity
    always_comb begin
        ram_addr  = bus.address[IDX_W-1:0];
        ram_we    = '0;
        ram_wdata = pack_word(bus.writedata);
        if (clearing) begin
            ram_addr  = clear_ptr[IDX_W-1:0];
            ram_we    = '1;
            ram_wdata = '0;
        end else if (wr_acc && in_rng) begin
            ram_we = bus.byteenable;
        end
    end

    onchip_ram_core #(
        .LANES   (LANES),
        .LANE_W  (LANE_W),
        .DEPTH   (DEPTH),
        .IDX_W   (IDX_W),
        .OUT_REG ((READ_LAT >= READ_LAT_MAX) ? 1 : 0)
    ) u_core (
        .clk   (clk),
        .en    (~stall),
        .addr  (ram_addr),
        .we    (ram_we),
        .wdata (ram_wdata),
        .re    (rd_acc),
        .q     (ram_q)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) oor_err <= 1'b0;
        else if (acc && !in_rng) oor_err <= 1'b1;
    end

    // Stage p0: qualifiers aligned with the RAM read register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) vld_p0 <= 1'b0;
        else if (!stall) vld_p0 <= rd_acc;
    end

    always_ff @(posedge clk) begin
        if (!stall) begin
            oor_p0 <= ~in_rng;
`ifdef ONCHIP_RAM_PARITY_EN
            be_p0   <= bus.byteenable;
            addr_p0 <= bus.address;
`endif
        end
    end

    // Stage p1: qualifiers aligned with the optional output register
    generate
        if (READ_LAT >= READ_LAT_MAX) begin : g_lat2
            logic vld_p1, oor_p1;
`ifdef ONCHIP_RAM_PARITY_EN
            logic [LANES-1:0]  be_p1;
            logic [ADDR_W-1:0] addr_p1;
`endif
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) vld_p1 <= 1'b0;
                else if (!stall) vld_p1 <= vld_p0;
            end
            always_ff @(posedge clk) begin
                if (!stall) begin
                    oor_p1 <= oor_p0;
`ifdef ONCHIP_RAM_PARITY_EN
                    be_p1   <= be_p0;
                    addr_p1 <= addr_p0;
`endif
                end
            end
            assign vld_out = vld_p1;
            assign oor_out = oor_p1;
`ifdef ONCHIP_RAM_PARITY_EN
            assign be_out   = be_p1;
            assign addr_out = addr_p1;
`endif
        end else begin : g_lat1
            assign vld_out = vld_p0;
            assign oor_out = oor_p0;
`ifdef ONCHIP_RAM_PARITY_EN
            assign be_out   = be_p0;
            assign addr_out = addr_p0;
`endif
        end
    endgenerate

    // A pending pulse is masked, not consumed, while frozen, so it reappears on resume
    assign bus.readdatavalid = vld_out & ~stall;
    assign bus.readdata      = (bus.readdatavalid & ~oor_out) ? unpack_word(ram_q) : '0;

`ifdef ONCHIP_RAM_PARITY_EN
    always_comb begin
        lane_bad = '0;
        for (int i = 0; i < LANES; i++) lane_bad[i] = ^ram_q[i*LANE_W +: LANE_W];
    end

    assign parity_err = bus.readdatavalid & ~oor_out & (|(lane_bad & be_out));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            par_seen        <= 1'b0;
            parity_err_addr <= '0;
        end else if (parity_err && !par_seen) begin
            par_seen        <= 1'b1;
            parity_err_addr <= addr_out;
        end
    end
`endif
endmodule

// File: tb/tb_onchip_ram_pipelined.sv
// tb_onchip_ram_pipelined: self-checking bench for onchip_ram_pipelined (DEPTH=16, READ_LAT=2).
// Reads push their expected word into a scoreboard when accepted; a negedge monitor pops
// and checks data and latency on every readdatavalid.
module tb_onchip_ram_pipelined;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam int DEPTH  = 16;
    localparam int RL     = 2;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic clken = 1'b1;
    logic reset_req = 1'b0;
    logic oor_err;
`ifdef ONCHIP_RAM_PARITY_EN
    logic              parity_err;
    logic [ADDR_W-1:0] parity_err_addr;
`endif

    onchip_ram_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    onchip_ram_pipelined #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .READ_LAT(RL), .CLEAR_EN(1)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .bus       (bus),
        .clken     (clken),
        .reset_req (reset_req),
        .oor_err   (oor_err)
`ifdef ONCHIP_RAM_PARITY_EN
        ,
        .parity_err      (parity_err),
        .parity_err_addr (parity_err_addr)
`endif
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc = 0;
    int stall_cnt = 0;

    typedef struct {
        logic [DATA_W-1:0] data;
        logic              perr;
        int                acc_cyc;
        int                stall_snap;
    } exp_t;
    exp_t sb[$];

    typedef struct {
        logic              rd;
        logic              wr;
        logic [ADDR_W-1:0] addr;
        logic [3:0]        be;
        logic [31:0]       wd;
        logic [31:0]       exp;
        logic              exp_oor;
    } vec_t;
    vec_t vt[19];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", nm, act, exp);
        end
    endtask

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!clken || reset_req) stall_cnt <= stall_cnt + 1;
    end

    // Monitor: scoreboard pop and compare
    always @(negedge clk) begin
        if (!reset_n) begin
            sb.delete();
        end else if (bus.readdatavalid) begin
            if (sb.size() == 0) begin
                chk("spurious_rdv", 64'(sb.size()), 64'(1));
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("rd_data", 64'(bus.readdata), 64'(e.data));
                chk("rd_lat", 64'(cyc - e.acc_cyc), 64'(RL + stall_cnt - e.stall_snap));
`ifdef ONCHIP_RAM_PARITY_EN
                chk("parity_err", 64'(parity_err), 64'(e.perr));
`endif
            end
        end
    end

    task automatic do_op(input logic rd, input logic wr, input logic [ADDR_W-1:0] a,
                         input logic [3:0] be, input logic [31:0] wd,
                         input logic [31:0] exp, input logic perr);
        int w;
        bus.chipselect = 1'b1;
        bus.read       = rd;
        bus.write      = wr;
        bus.address    = a;
        bus.byteenable = be;
        bus.writedata  = wd;
        w = 0;
        @(negedge clk);
        while (bus.waitrequest && w < 50) begin
            w++;
            @(negedge clk);
        end
        if (bus.waitrequest) chk("accept_timeout", 64'(bus.waitrequest), 64'(0));
        else if (rd && !wr) sb.push_back('{data: exp, perr: perr, acc_cyc: cyc, stall_snap: stall_cnt});
        @(posedge clk);
        #1;
        bus.chipselect = 1'b0;
        bus.read       = 1'b0;
        bus.write      = 1'b0;
    endtask

    task automatic count_wait(output int n);
        n = 0;
        @(negedge clk);
        while (bus.waitrequest && n < 100) begin
            n++;
            @(negedge clk);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        repeat (RL + 4) @(negedge clk);
        chk("sb_empty", 64'(sb.size()), 64'(0));
        @(posedge clk);
        #1;
    endtask

    task automatic read_all_zero();
        for (int i = 0; i < DEPTH; i++) do_op(1'b1, 1'b0, ADDR_W'(i), 4'hF, 32'h0, 32'h0, 1'b0);
        drain();
    endtask

    task automatic stall_read(input logic [ADDR_W-1:0] a, input logic [31:0] exp,
                              input bit use_req, input int n);
        int got;
        do_op(1'b1, 1'b0, a, 4'hF, 32'h0, exp, 1'b0);
        if (use_req) reset_req = 1'b1;
        else clken = 1'b0;
        got = 0;
        for (int j = 1; j <= 12; j++) begin
            @(negedge clk);
            if (j == 1) chk("stall_wait", 64'(bus.waitrequest), 64'(1));
            if (got == 0 && bus.readdatavalid) got = j;
            if (j == n) begin
                @(posedge clk);
                #1;
                clken = 1'b1;
                reset_req = 1'b0;
            end
        end
        chk("stall_lat", 64'(got), 64'(RL + n));
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish, required finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        //          rd    wr    addr   be       wdata         expected      oor
        vt[0]  = '{1'b0, 1'b1, 5'd3,  4'b0101, 32'hA5A5A5A5, 32'h00000000, 1'b0};
        vt[1]  = '{1'b1, 1'b0, 5'd3,  4'b1111, 32'h0,        32'h00A500A5, 1'b0};
        vt[2]  = '{1'b0, 1'b1, 5'd0,  4'b1111, 32'h11223344, 32'h00000000, 1'b0};
        vt[3]  = '{1'b0, 1'b1, 5'd1,  4'b1111, 32'hDEADBEEF, 32'h00000000, 1'b0};
        vt[4]  = '{1'b0, 1'b1, 5'd2,  4'b1000, 32'hCAFEF00D, 32'h00000000, 1'b0};
        vt[5]  = '{1'b1, 1'b0, 5'd0,  4'b1111, 32'h0,        32'h11223344, 1'b0};
        vt[6]  = '{1'b1, 1'b0, 5'd1,  4'b1111, 32'h0,        32'hDEADBEEF, 1'b0};
        vt[7]  = '{1'b1, 1'b0, 5'd2,  4'b1111, 32'h0,        32'hCA000000, 1'b0};
        vt[8]  = '{1'b1, 1'b0, 5'd3,  4'b1111, 32'h0,        32'h00A500A5, 1'b0};
        vt[9]  = '{1'b0, 1'b1, 5'd3,  4'b1010, 32'h5A5A5A5A, 32'h00000000, 1'b0};
        vt[10] = '{1'b1, 1'b0, 5'd3,  4'b1111, 32'h0,        32'h5AA55AA5, 1'b0};
        vt[11] = '{1'b0, 1'b1, 5'd15, 4'b1111, 32'hFFFFFFFF, 32'h00000000, 1'b0};
        vt[12] = '{1'b1, 1'b0, 5'd15, 4'b1111, 32'h0,        32'hFFFFFFFF, 1'b0};
        vt[13] = '{1'b1, 1'b0, 5'd17, 4'b1111, 32'h0,        32'h00000000, 1'b1};
        vt[14] = '{1'b0, 1'b1, 5'd17, 4'b1111, 32'h12345678, 32'h00000000, 1'b1};
        vt[15] = '{1'b1, 1'b0, 5'd1,  4'b1111, 32'h0,        32'hDEADBEEF, 1'b1};
        vt[16] = '{1'b1, 1'b1, 5'd4,  4'b1111, 32'h77777777, 32'h00000000, 1'b1};
        vt[17] = '{1'b1, 1'b0, 5'd4,  4'b1111, 32'h0,        32'h77777777, 1'b1};
        vt[18] = '{1'b1, 1'b0, 5'd14, 4'b1111, 32'h0,        32'h00000000, 1'b1};

        bus.chipselect = 1'b0;
        bus.read       = 1'b0;
        bus.write      = 1'b0;
        bus.address    = '0;
        bus.byteenable = '0;
        bus.writedata  = '0;

        // Reset values
        repeat (3) @(negedge clk);
        chk("rst_waitrequest", 64'(bus.waitrequest), 64'(1));
        chk("rst_rdv", 64'(bus.readdatavalid), 64'(0));
        chk("rst_readdata", 64'(bus.readdata), 64'(0));
        chk("rst_oor_err", 64'(oor_err), 64'(0));

        // Clear sweep after reset release, then everything reads zero
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        count_wait(n);
        chk("clear_cycles", 64'(n), 64'(DEPTH));
        read_all_zero();

        // Table: byte lanes, read-after-write, streaming reads, out-of-range, read+write
        for (int i = 0; i < 19; i++) begin
            do_op(vt[i].rd, vt[i].wr, vt[i].addr, vt[i].be, vt[i].wd, vt[i].exp, 1'b0);
            chk($sformatf("oor_err_v%0d", i), 64'(oor_err), 64'(vt[i].exp_oor));
        end
        drain();

        // Freeze during an in-flight read: by clken, then by reset_req
        do_op(1'b0, 1'b1, 5'd6, 4'hF, 32'h0BADF00D, 32'h0, 1'b0);
        stall_read(5'd6, 32'h0BADF00D, 1'b0, 3);
        do_op(1'b0, 1'b1, 5'd7, 4'hF, 32'h600DCAFE, 32'h0, 1'b0);
        stall_read(5'd7, 32'h600DCAFE, 1'b1, 2);
        drain();

`ifdef ONCHIP_RAM_PARITY_EN
        // Corrupt one stored bit and read it back uncorrected with a parity flag
        do_op(1'b0, 1'b1, 5'd5, 4'hF, 32'h12345678, 32'h0, 1'b0);
        dut.u_core.mem[5][0] = ~dut.u_core.mem[5][0];
        do_op(1'b1, 1'b0, 5'd5, 4'hF, 32'h0, 32'h12345679, 1'b1);
        do_op(1'b1, 1'b0, 5'd4, 4'hF, 32'h0, 32'h77777777, 1'b0);
        drain();
        chk("parity_err_addr", 64'(parity_err_addr), 64'(5));
`endif

        // Reset in the middle of a read: pulse flushed, sweep restarts
        do_op(1'b1, 1'b0, 5'd0, 4'hF, 32'h0, 32'h11223344, 1'b0);
        reset_n = 1'b0;
        @(negedge clk);
        chk("flush_rdv", 64'(bus.readdatavalid), 64'(0));
        chk("flush_oor_err", 64'(oor_err), 64'(0));
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        count_wait(n);
        chk("clear_cycles_2", 64'(n), 64'(DEPTH));

        // Reset in the middle of the sweep: it starts over from word 0
        do_op(1'b0, 1'b1, 5'd9, 4'hF, 32'h99999999, 32'h0, 1'b0);
        reset_n = 1'b0;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        reset_n = 1'b0;
        @(negedge clk);
        chk("midclear_waitrequest", 64'(bus.waitrequest), 64'(1));
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        count_wait(n);
        chk("clear_cycles_3", 64'(n), 64'(DEPTH));
        read_all_zero();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
